// File: rtl/aes_selftest_pkg.sv
// Shared definitions for the AES known-answer self-test controller:
// the FSM state encoding and the known-answer vector ROM.
package aes_selftest_pkg;

  localparam int KAT_COUNT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_CHECK,
    ST_NEXT,
    ST_DONE
  } state_t;

  // Vector 0: FIPS-197 C.1, 1: FIPS-197 appendix B, 2: all-zero key/pt,
  // 3: all-ones key with zero plaintext.
  function automatic logic [127:0] kat_key(input logic [1:0] vec);
    case (vec)
      2'd0:    kat_key = 128'h000102030405060708090a0b0c0d0e0f;
      2'd1:    kat_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      2'd2:    kat_key = 128'h00000000000000000000000000000000;
      default: kat_key = 128'hffffffffffffffffffffffffffffffff;
    endcase
  endfunction

  function automatic logic [127:0] kat_pt(input logic [1:0] vec);
    case (vec)
      2'd0:    kat_pt = 128'h00112233445566778899aabbccddeeff;
      2'd1:    kat_pt = 128'h3243f6a8885a308d313198a2e0370734;
      2'd2:    kat_pt = 128'h00000000000000000000000000000000;
      default: kat_pt = 128'h00000000000000000000000000000000;
    endcase
  endfunction

  function automatic logic [127:0] kat_ct(input logic [1:0] vec);
    case (vec)
      2'd0:    kat_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      2'd1:    kat_ct = 128'h3925841d02dc09fbdc118597196a0b32;
      2'd2:    kat_ct = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
      default: kat_ct = 128'ha1f6258c877d5fcd8964484538bfc92c;
    endcase
  endfunction

  // Op index layout: vector in [2:1], direction in [0] (0 = encrypt).
  function automatic logic [127:0] kat_op_data(input logic [2:0] op);
    return op[0] ? kat_ct(op[2:1]) : kat_pt(op[2:1]);
  endfunction

  function automatic logic [127:0] kat_op_expect(input logic [2:0] op);
    return op[0] ? kat_pt(op[2:1]) : kat_ct(op[2:1]);
  endfunction

endpackage

// File: rtl/aes_selftest_ctrl_if.sv
// Bundle of buttons, AES core handshake and status signals of the
// self-test controller. master = controller side, slave = board/core side.
interface aes_selftest_ctrl_if;
  logic         btn_run;
  logic         btn_mode;
  logic [3:0]   vec_sel;
  logic         core_start;
  logic         core_enc_dec;
  logic [127:0] core_data;
  logic [127:0] core_key;
  logic [127:0] core_result;
  logic         core_ready;
  logic         sweep_mode;
  logic         busy;
  logic         done;
  logic         timeout;
  logic [3:0]   pass_cnt;
  logic [3:0]   fail_cnt;
  logic [3:0]   first_fail_idx;
  logic [127:0] last_result;

  modport master (
    input  btn_run, btn_mode, vec_sel, core_result, core_ready,
    output core_start, core_enc_dec, core_data, core_key,
    output sweep_mode, busy, done, timeout,
    output pass_cnt, fail_cnt, first_fail_idx, last_result
  );

  modport slave (
    output btn_run, btn_mode, vec_sel, core_result, core_ready,
    input  core_start, core_enc_dec, core_data, core_key,
    input  sweep_mode, busy, done, timeout,
    input  pass_cnt, fail_cnt, first_fail_idx, last_result
  );
endinterface

// File: rtl/aes_selftest_ctrl_btn_debounce.sv
// Button debouncer: synchronises the raw input, samples it every
// 2^DB_BITS cycles and emits a one-cycle pulse on a sampled rising edge.
// Reset assumes the button is pressed, so a button held through reset
// must be released and pressed again before it produces a pulse.
module btn_debounce #(
  parameter int DB_BITS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic [DB_BITS-1:0] div_q;
  logic [1:0]         sync_q;
  logic               stable_q;
  logic               pulse_q;
  logic               tick;

  assign tick    = &div_q;
  assign pulse_o = pulse_q;

  // Synchroniser, sample divider and sampled-edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      pulse_q  <= 1'b0;
    end else begin
      div_q   <= div_q + 1'b1;
      sync_q  <= {sync_q[0], btn_i};
      pulse_q <= 1'b0;
      if (tick) begin
        stable_q <= sync_q[1];
        pulse_q  <= sync_q[1] & ~stable_q;
      end
    end
  end

endmodule

// File: rtl/aes_selftest_ctrl.sv
// AES known-answer self-test controller. Runs encrypt and decrypt of each
// ROM vector through an external AES core and tallies pass/fail.
// Optional watchdog on core operations: define AES_SELFTEST_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for a run pulse after reset
// LOAD     | drive key/data/direction of the current op
// START    | one-cycle core_start pulse
// WAIT_LO  | wait for the core to drop ready
// WAIT_HI  | wait for ready, capture result
// CHECK    | compare result with expected value, update tallies
// NEXT     | advance op or finish
// DONE     | run complete, results held until the next run
module aes_selftest_ctrl
  import aes_selftest_pkg::*;
#(
  parameter int NUM_VEC = 4,
  parameter int DB_BITS = 20,
  parameter int TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst,
  aes_selftest_ctrl_if.master bus
);

  if (NUM_VEC < 1 || NUM_VEC > KAT_COUNT || TIMEOUT < 1) begin : g_bad_param
    $error("aes_selftest_ctrl: NUM_VEC must be 1..KAT_COUNT and TIMEOUT >= 1");
  end

  localparam logic [1:0] VEC_MAX = 2'(NUM_VEC - 1);
  localparam logic [2:0] OP_MAX  = 3'(2 * NUM_VEC - 1);

  state_t       state_q;
  logic [2:0]   op_q, op_last_q;
  logic [1:0]   vec_d;
  logic [2:0]   first_op_d, last_op_d;
  logic         run_pulse, mode_pulse, wd_expired;
  logic         start_q, enc_q, sweep_q, busy_q, done_q, timeout_q;
  logic [127:0] data_q, key_q, last_result_q;
  logic [3:0]   pass_q, fail_q, ffi_q;

  btn_debounce #(.DB_BITS(DB_BITS)) u_db_run (
    .clk(clk), .rst(rst), .btn_i(bus.btn_run), .pulse_o(run_pulse)
  );

  btn_debounce #(.DB_BITS(DB_BITS)) u_db_mode (
    .clk(clk), .rst(rst), .btn_i(bus.btn_mode), .pulse_o(mode_pulse)
  );

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Op range of the next run; single mode clamps vec_sel to the last vector.
  always_comb begin
    vec_d      = (bus.vec_sel > {2'b00, VEC_MAX}) ? VEC_MAX : bus.vec_sel[1:0];
    first_op_d = sweep_q ? 3'd0 : {vec_d, 1'b0};
    last_op_d  = sweep_q ? OP_MAX : {vec_d, 1'b1};
  end

`ifdef AES_SELFTEST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;

  // Watchdog down-counter, reloaded at START and spanning both wait states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else if (state_q == ST_START) begin
      wd_q <= WD_W'(TIMEOUT - 1);
    end else if ((state_q == ST_WAIT_LO || state_q == ST_WAIT_HI) && wd_q != '0) begin
      wd_q <= wd_q - 1'b1;
    end
  end

  assign wd_expired = (state_q == ST_WAIT_LO || state_q == ST_WAIT_HI) && (wd_q == '0);
`else
  assign wd_expired = 1'b0;
`endif

  // Sequencing FSM with registered core drive and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      op_last_q     <= '0;
      start_q       <= 1'b0;
      enc_q         <= 1'b0;
      sweep_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      data_q        <= '0;
      key_q         <= '0;
      last_result_q <= '0;
      pass_q        <= '0;
      fail_q        <= '0;
      ffi_q         <= 4'hF;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (mode_pulse) sweep_q <= ~sweep_q;
          if (run_pulse) begin
            pass_q    <= '0;
            fail_q    <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            ffi_q     <= 4'hF;
            busy_q    <= 1'b1;
            op_q      <= first_op_d;
            op_last_q <= last_op_d;
            state_q   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          enc_q   <= ~op_q[0];
          data_q  <= kat_op_data(op_q);
          key_q   <= kat_key(op_q[2:1]);
          start_q <= 1'b1;
          state_q <= ST_START;
        end
        ST_START: begin
          start_q <= 1'b0;
          state_q <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!bus.core_ready) begin
            state_q <= ST_WAIT_HI;
          end else if (wd_expired) begin
            fail_q    <= sat_inc(fail_q);
            timeout_q <= 1'b1;
            if (ffi_q == 4'hF) ffi_q <= {1'b0, op_q};
            state_q   <= ST_NEXT;
          end
        end
        ST_WAIT_HI: begin
          if (bus.core_ready) begin
            last_result_q <= bus.core_result;
            state_q       <= ST_CHECK;
          end else if (wd_expired) begin
            fail_q    <= sat_inc(fail_q);
            timeout_q <= 1'b1;
            if (ffi_q == 4'hF) ffi_q <= {1'b0, op_q};
            state_q   <= ST_NEXT;
          end
        end
        ST_CHECK: begin
          if (last_result_q == kat_op_expect(op_q)) begin
            pass_q <= sat_inc(pass_q);
          end else begin
            fail_q <= sat_inc(fail_q);
            if (ffi_q == 4'hF) ffi_q <= {1'b0, op_q};
          end
          state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          if (op_q == op_last_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            op_q    <= op_q + 3'd1;
            state_q <= ST_LOAD;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.core_start     = start_q;
  assign bus.core_enc_dec   = enc_q;
  assign bus.core_data      = data_q;
  assign bus.core_key       = key_q;
  assign bus.sweep_mode     = sweep_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.timeout        = timeout_q;
  assign bus.pass_cnt       = pass_q;
  assign bus.fail_cnt       = fail_q;
  assign bus.first_fail_idx = ffi_q;
  assign bus.last_result    = last_result_q;

endmodule

// File: tb/tb_aes_selftest_ctrl.sv
// Scoreboard bench for aes_selftest_ctrl with a behavioural AES core that
// answers from a hand-entered known-answer table.
module tb_aes_selftest_ctrl;

  localparam int NUM_VEC = 4;
  localparam int DB_BITS = 2;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;

  aes_selftest_ctrl_if bus ();

  aes_selftest_ctrl #(.NUM_VEC(NUM_VEC), .DB_BITS(DB_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         enc;
    logic [127:0] data;
    logic [127:0] key;
  } op_t;

  typedef struct packed {
    logic [3:0] pass;
    logic [3:0] fail;
    logic [3:0] ffi;
    logic       tmo;
  } sum_t;

  op_t  op_q[$];
  sum_t sum_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   fault_en = 1'b0;
  bit   stuck_en = 1'b0;

  function automatic logic [127:0] tb_key(input int v);
    case (v)
      0:       return 128'h000102030405060708090a0b0c0d0e0f;
      1:       return 128'h2b7e151628aed2a6abf7158809cf4f3c;
      2:       return 128'h0;
      default: return {128{1'b1}};
    endcase
  endfunction

  function automatic logic [127:0] tb_pt(input int v);
    case (v)
      0:       return 128'h00112233445566778899aabbccddeeff;
      1:       return 128'h3243f6a8885a308d313198a2e0370734;
      default: return 128'h0;
    endcase
  endfunction

  function automatic logic [127:0] tb_ct(input int v);
    case (v)
      0:       return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      1:       return 128'h3925841d02dc09fbdc118597196a0b32;
      2:       return 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
      default: return 128'ha1f6258c877d5fcd8964484538bfc92c;
    endcase
  endfunction

  function automatic logic [127:0] aes_model(input logic enc, input logic [127:0] key,
                                             input logic [127:0] data);
    logic [127:0] r;
    r = ~data;
    for (int v = 0; v < 4; v++) begin
      if (key == tb_key(v)) begin
        if (enc && data == tb_pt(v)) r = tb_ct(v);
        if (!enc && data == tb_ct(v)) r = tb_pt(v);
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic push_vec(input int v);
    op_q.push_back('{enc: 1'b1, data: tb_pt(v), key: tb_key(v)});
    op_q.push_back('{enc: 1'b0, data: tb_ct(v), key: tb_key(v)});
  endtask

  task automatic exp_sum(input logic [3:0] p, input logic [3:0] f, input logic [3:0] i,
                         input logic t);
    sum_q.push_back('{pass: p, fail: f, ffi: i, tmo: t});
  endtask

  task automatic press_run();
    bus.btn_run = 1'b1;
    repeat (8) @(negedge clk);
    bus.btn_run = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic press_mode();
    bus.btn_mode = 1'b1;
    repeat (8) @(negedge clk);
    bus.btn_mode = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("run_started", 128'(bus.busy), 128'(1));
    n = 0;
    while (bus.busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("run_finished", 128'(bus.busy), 128'(0));
  endtask

  // Behavioural core: drops ready on start, returns the result 12 cycles later.
  logic [127:0] m_data, m_key;
  logic         m_enc;
  int           m_cnt;
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      bus.core_ready  = 1'b1;
      bus.core_result = '0;
      m_cnt           = 0;
    end else if (!stuck_en) begin
      if (bus.core_start) begin
        m_enc          = bus.core_enc_dec;
        m_data         = bus.core_data;
        m_key          = bus.core_key;
        m_cnt          = 12;
        bus.core_ready = 1'b0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          bus.core_result = aes_model(m_enc, m_key, m_data);
          if (fault_en && m_key == 128'h0 && !m_enc) bus.core_result[0] = ~bus.core_result[0];
          bus.core_ready = 1'b1;
        end
      end
    end
  end

  // Monitor: checks each core_start against the op queue and each
  // completed run against the summary queue.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    op_t  e;
    sum_t s;
    if (bus.core_start) begin
      if (op_q.size() == 0) begin
        chk("unexpected_start", 128'(bus.core_start), 128'(0));
      end else begin
        e = op_q.pop_front();
        chk("core_enc_dec", 128'(bus.core_enc_dec), 128'(e.enc));
        chk("core_data", bus.core_data, e.data);
        chk("core_key", bus.core_key, e.key);
      end
    end
    if (bus.done && !done_prev) begin
      if (sum_q.size() == 0) begin
        chk("unexpected_done", 128'(bus.done), 128'(0));
      end else begin
        s = sum_q.pop_front();
        chk("pass_cnt", 128'(bus.pass_cnt), 128'(s.pass));
        chk("fail_cnt", 128'(bus.fail_cnt), 128'(s.fail));
        chk("first_fail_idx", 128'(bus.first_fail_idx), 128'(s.ffi));
        chk("timeout", 128'(bus.timeout), 128'(s.tmo));
      end
    end
    done_prev = bus.done;
  end

  initial begin
    int n;
    rst          = 1'b1;
    bus.btn_run  = 1'b1;
    bus.btn_mode = 1'b0;
    bus.vec_sel  = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_done", 128'(bus.done), 128'(0));
    chk("rst_start", 128'(bus.core_start), 128'(0));
    chk("rst_pass", 128'(bus.pass_cnt), 128'(0));
    chk("rst_fail", 128'(bus.fail_cnt), 128'(0));
    chk("rst_ffi", 128'(bus.first_fail_idx), 128'hF);
    chk("rst_sweep", 128'(bus.sweep_mode), 128'(0));
    chk("rst_timeout", 128'(bus.timeout), 128'(0));
    chk("rst_last_result", bus.last_result, 128'h0);
    rst = 1'b0;

    // Button held through reset must not start a run.
    repeat (20) @(negedge clk);
    chk("held_run_no_start", 128'(bus.busy), 128'(0));
    bus.btn_run = 1'b0;
    repeat (8) @(negedge clk);

    // Single mode, vector 0.
    push_vec(0);
    exp_sum(4'd2, 4'd0, 4'hF, 1'b0);
    press_run();
    wait_done();
    chk("single0_done", 128'(bus.done), 128'(1));
    chk("single0_last_result", bus.last_result, 128'h00112233445566778899aabbccddeeff);

    // Single mode, out-of-range vec_sel clamps to vector 3.
    bus.vec_sel = 4'd9;
    push_vec(3);
    exp_sum(4'd2, 4'd0, 4'hF, 1'b0);
    press_run();
    wait_done();

    press_mode();
    chk("sweep_on", 128'(bus.sweep_mode), 128'(1));

    // Sweep with run and mode presses while busy, both ignored.
    for (int v = 0; v < 4; v++) push_vec(v);
    exp_sum(4'd8, 4'd0, 4'hF, 1'b0);
    press_run();
    press_run();
    press_mode();
    chk("busy_during_presses", 128'(bus.busy), 128'(1));
    wait_done();
    chk("sweep_kept", 128'(bus.sweep_mode), 128'(1));

    // Sweep with a corrupted result on vector 2 decrypt (op 5).
    fault_en = 1'b1;
    for (int v = 0; v < 4; v++) push_vec(v);
    exp_sum(4'd7, 4'd1, 4'd5, 1'b0);
    press_run();
    wait_done();
    fault_en = 1'b0;

`ifdef AES_SELFTEST_TIMEOUT_EN
    // Core never drops ready: every op times out.
    stuck_en = 1'b1;
    for (int v = 0; v < 4; v++) push_vec(v);
    exp_sum(4'd0, 4'd8, 4'd0, 1'b1);
    press_run();
    wait_done();
    chk("stuck_done", 128'(bus.done), 128'(1));
    stuck_en = 1'b0;
`endif

    // Reset in WAIT_HI of the first op of a single-mode run.
    press_mode();
    chk("sweep_off", 128'(bus.sweep_mode), 128'(0));
    bus.vec_sel = 4'd0;
    op_q.push_back('{enc: 1'b1, data: tb_pt(0), key: tb_key(0)});
    bus.btn_run = 1'b1;
    n = 0;
    while (bus.core_ready !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_wait", 128'(bus.core_ready), 128'(0));
    bus.btn_run = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 128'(bus.busy), 128'(0));
    chk("abort_start", 128'(bus.core_start), 128'(0));
    chk("abort_pass", 128'(bus.pass_cnt), 128'(0));
    chk("abort_fail", 128'(bus.fail_cnt), 128'(0));
    chk("abort_ffi", 128'(bus.first_fail_idx), 128'hF);
    chk("abort_last_result", bus.last_result, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_restart_after_reset", 128'(bus.busy), 128'(0));

    chk("ops_left", 128'(op_q.size()), 128'(0));
    chk("sums_left", 128'(sum_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_selftest_ctrl.md
AES_SELFTEST_CTRL -- requirements
Module: aes_selftest_ctrl

Interface
REQ-001 Parameter NUM_VEC, default 4, number of known-answer vectors exercised; legal range 1..4.
REQ-002 Parameter DB_BITS, default 20, debounce sample-counter width; buttons are sampled every 2^DB_BITS cycles.
REQ-003 Parameter TIMEOUT, default 64, maximum cycles allowed per core operation.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 btn_run  in  1  raw run button.
REQ-007 btn_mode  in  1  raw button; toggles single/sweep mode.
REQ-008 vec_sel  in  4  vector index used in single mode.
REQ-009 core_start  out  1  one-cycle start pulse to the AES core.
REQ-010 core_enc_dec  out  1  1 = encrypt, 0 = decrypt.
REQ-011 core_data  out  128  core data input.
REQ-012 core_key  out  128  core key input.
REQ-013 core_result  in  128  core data output.
REQ-014 core_ready  in  1  core idle / result valid.
REQ-015 sweep_mode  out  1  1 = run all vectors, 0 = run vec_sel only.
REQ-016 busy, done, timeout  out  1 each  status flags.
REQ-017 pass_cnt, fail_cnt  out  4 each  operation tallies.
REQ-018 first_fail_idx  out  4  op index of the first miscompare; 4'hF if there is none.
REQ-019 last_result  out  128  most recent core_result captured.

Function
REQ-020 Each vector SHALL run two ops: encrypt (pt -> expect ct), then decrypt (ct -> expect pt); op index = 2*vector + dir, with dir 0 = encrypt.
REQ-021 Debounced rising edges of btn_run and btn_mode SHALL each yield exactly one 1-cycle internal pulse.
REQ-022 A btn_mode pulse SHALL toggle sweep_mode only in IDLE or DONE; it is ignored while busy.
REQ-023 FSM states: IDLE, LOAD, START, WAIT_LO, WAIT_HI, CHECK, NEXT, DONE.
REQ-024 IDLE/DONE + run pulse -> LOAD: clear counters, done and timeout; set first_fail_idx=F; set busy=1.
REQ-025 LOAD: drive core_data, core_key and core_enc_dec from the ROM for the current op; they SHALL stay stable until CHECK exits.
REQ-026 START: core_start=1 for exactly one cycle -> WAIT_LO.
REQ-027 WAIT_LO waits for core_ready=0; WAIT_HI waits for core_ready=1, then captures core_result into last_result -> CHECK.
REQ-028 CHECK: on a match, pass_cnt+1; on a miscompare, fail_cnt+1 and, if first_fail_idx==F, load the op index.
REQ-029 NEXT: advance to the next op; after the last op -> DONE with busy=0 and done=1; done holds until the next run.
REQ-030 In single mode the op range is vector min(vec_sel, NUM_VEC-1), 2 ops; in sweep mode it is 0..2*NUM_VEC-1.
REQ-031 Run pulses while busy SHALL be ignored.
REQ-032 Counters SHALL saturate at 15; they never wrap.

Reset
REQ-033 While rst=1: state IDLE, all outputs 0 except first_fail_idx=F, sweep_mode=0; takes effect immediately, including mid-operation (core_start deasserts asynchronously).
REQ-034 After reset deassertion, no run SHALL start without a fresh debounced btn_run edge.

Configuration
REQ-035 Macro AES_SELFTEST_TIMEOUT_EN defined: a cycle counter spans WAIT_LO+WAIT_HI; when it reaches TIMEOUT, fail_cnt+1, timeout=1 (sticky until next run), first-fail logic applies, last_result is unchanged, -> NEXT.
REQ-036 Macro undefined: no watchdog logic; WAIT states wait indefinitely; timeout tied to 0.

Structure
REQ-037 Shared package aes_selftest_pkg holds the KAT ROM (key/pt/ct for FIPS-197 C.1, FIPS-197 B, all-zero, all-ones), KAT_COUNT=4, and the FSM state enum.
REQ-038 One sub-module, btn_debounce (sampler plus edge pulse, parametrised by DB_BITS), instantiated twice.

Verification
REQ-039 DB_BITS=2, ideal core model (latency 12), single mode, vec_sel=0, run -> core_data=00112233445566778899aabbccddeeff then 69c4e0d86a7b0430d8cdb78070b4c55a; pass_cnt=2, fail_cnt=0, done=1.
REQ-040 Sweep mode, NUM_VEC=4, ideal core -> 8 core_start pulses; pass_cnt=8, fail_cnt=0, first_fail_idx=F.
REQ-041 Core model flips result bit 0 on vector 2 decrypt -> fail_cnt=1, pass_cnt=7, first_fail_idx=5.
REQ-042 AES_SELFTEST_TIMEOUT_EN, TIMEOUT=16, core_ready stuck high -> timeout=1 after 16 WAIT cycles; all 8 ops fail; fail_cnt=8; done=1.
REQ-043 rst asserted in WAIT_HI -> same cycle: busy=0, core_start=0, counters 0, first_fail_idx=F; btn_run pressed while busy -> no restart and no counter change.
REQ-044 vec_sel=9, NUM_VEC=4, single mode -> vector 3 exercised; pass_cnt=2.
